// File: rtl/mem_arbiter.sv
// Two-requester (IFU read-only, LSU read/write) arbiter in front of the single-port memory.
// Define MEM_ARB_RR_EN for round-robin conflict resolution; otherwise LSU has fixed priority.
module mem_arbiter #(
    parameter int unsigned BITSIZE = 32
) (
    input  logic               clk,
    input  logic               rst_i,
    input  logic               ifu_valid_i,
    input  logic [31:0]        ifu_addr_i,
    output logic               ifu_ready_o,
    output logic               ifu_rvalid_o,
    output logic [BITSIZE-1:0] ifu_rdata_o,
    input  logic               lsu_valid_i,
    input  logic               lsu_write_i,
    input  logic [1:0]         lsu_size_i,
    input  logic [31:0]        lsu_addr_i,
    input  logic [BITSIZE-1:0] lsu_wdata_i,
    output logic               lsu_ready_o,
    output logic               lsu_rvalid_o,
    output logic [BITSIZE-1:0] lsu_rdata_o,
    output logic               mem_valid_o,
    output logic               mem_write_o,
    output logic [1:0]         mem_write_size_o,
    output logic [31:0]        mem_addr_o,
    output logic [BITSIZE-1:0] mem_data_o,
    input  logic               mem_valid_i,
    input  logic [BITSIZE-1:0] mem_data_i
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t             state;
    logic               owner_lsu;
    logic               grant_lsu;
    logic               grant_ifu;
    logic               accept;

`ifdef MEM_ARB_RR_EN
    logic               last_lsu;

    // On conflict, the requester not granted last time wins.
    assign grant_lsu = lsu_valid_i && (!ifu_valid_i || !last_lsu);
`else
    assign grant_lsu = lsu_valid_i;
`endif
    assign grant_ifu = ifu_valid_i && !grant_lsu;

    // Ready is suppressed during reset so every output reads 0 while rst_i is high.
    assign accept      = (state == IDLE) && !rst_i;
    assign ifu_ready_o = accept && grant_ifu;
    assign lsu_ready_o = accept && grant_lsu;

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state            <= IDLE;
            owner_lsu        <= 1'b0;
            ifu_rvalid_o     <= 1'b0;
            ifu_rdata_o      <= '0;
            lsu_rvalid_o     <= 1'b0;
            lsu_rdata_o      <= '0;
            mem_valid_o      <= 1'b0;
            mem_write_o      <= 1'b0;
            mem_write_size_o <= 2'b00;
            mem_addr_o       <= '0;
            mem_data_o       <= '0;
`ifdef MEM_ARB_RR_EN
            last_lsu         <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_lsu || grant_ifu) begin
                        owner_lsu        <= grant_lsu;
                        mem_valid_o      <= 1'b1;
                        mem_write_o      <= grant_lsu && lsu_write_i;
                        mem_write_size_o <= grant_lsu ? lsu_size_i : 2'b10;
                        mem_addr_o       <= grant_lsu ? lsu_addr_i : ifu_addr_i;
                        mem_data_o       <= grant_lsu ? lsu_wdata_i : '0;
`ifdef MEM_ARB_RR_EN
                        last_lsu         <= grant_lsu;
`endif
                        state            <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_valid_i) begin
                        mem_valid_o <= 1'b0;
                        mem_write_o <= 1'b0;
                        if (owner_lsu) begin
                            lsu_rvalid_o <= 1'b1;
                            lsu_rdata_o  <= mem_write_o ? '0 : mem_data_i;
                        end else begin
                            ifu_rvalid_o <= 1'b1;
                            ifu_rdata_o  <= mem_data_i;
                        end
                        state <= RESP;
                    end
                end
                RESP: begin
                    ifu_rvalid_o <= 1'b0;
                    lsu_rvalid_o <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
